// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative multiply/multiply-accumulate unit.
package mult_pkg;

    typedef enum logic [1:0] {
        MUL_M   = 2'b00,
        MLA_M   = 2'b01,
        UMULL_M = 2'b10,
        SMULL_M = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_e;

    // Bit positions inside the {N,Z} flag vector.
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

endpackage

// File: rtl/mult_if.sv
// Operand/result bundle between the execute stage and the multiply unit.
interface mult_if #(
    parameter int WIDTH = 32
);

    logic             Start;
    logic             Flush;
    logic [1:0]       Mode;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [WIDTH-1:0] AccIn;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] ResultLo;
    logic [WIDTH-1:0] ResultHi;
    logic [1:0]       FlagsOut;

    modport master (
        output Start, Flush, Mode, SrcA, SrcB, AccIn,
        input  Busy, Done, ResultLo, ResultHi, FlagsOut
    );

    modport slave (
        input  Start, Flush, Mode, SrcA, SrcB, AccIn,
        output Busy, Done, ResultLo, ResultHi, FlagsOut
    );

endinterface

// File: rtl/mult_step.sv
// One iteration of shift-and-add: folds BITS_PER_CYCLE multiplier bits into the
// double-width product accumulator.
module mult_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int SHW            = $clog2(2*WIDTH) + 1
) (
    input  logic [2*WIDTH-1:0]        acc_in,
    input  logic [WIDTH-1:0]          multiplicand,
    input  logic [BITS_PER_CYCLE-1:0] mbits,
    input  logic [SHW-1:0]            shift,
    output logic [2*WIDTH-1:0]        acc_out
);

    logic [2*WIDTH-1:0] partial;

    always_comb begin
        partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mbits[i]) begin
                partial = partial + ({{WIDTH{1'b0}}, multiplicand} << i);
            end
        end
        acc_out = acc_in + (partial << shift);
    end

endmodule

// File: rtl/mult_unit.sv
// Iterative MUL/MLA/UMULL/SMULL unit: holds Busy while it retires multiplier
// bits, then pulses Done with registered results and {N,Z} flags.
module mult_unit
    import mult_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic  clk,
    input logic  reset,
    mult_if.slave bus
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = $clog2(STEPS + 1);
    localparam int SHW   = $clog2(2*WIDTH) + 1;

    generate
        if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) ||
            (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
            $error("mult_unit: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
        end
    endgenerate

    state_e             state, state_next;
    mode_e              mode_q;
    logic [WIDTH-1:0]   mcand_q, mplier_q, acc_q;
    logic               sign_q;
    logic [CW-1:0]      count_q;
    logic [2*WIDTH-1:0] prod_q, prod_step, prod_signed;
    logic               done_q;
    logic [WIDTH-1:0]   res_lo_q, res_hi_q;
    logic [1:0]         flags_q;

    logic               start_ok, last_step, is_smull, wide;
    logic [WIDTH-1:0]   a_mag, b_mag, fin_lo, fin_hi;
    logic [1:0]         fin_flags;
    logic [SHW-1:0]     shift;

    assign start_ok  = bus.Start && !bus.Flush;
    assign last_step = (count_q == CW'(STEPS - 1));
    assign shift     = SHW'(count_q) * SHW'(BITS_PER_CYCLE);
    assign is_smull  = (mode_e'(bus.Mode) == SMULL_M);

    // SMULL runs on magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
    assign a_mag = (is_smull && bus.SrcA[WIDTH-1]) ? -bus.SrcA : bus.SrcA;
    assign b_mag = (is_smull && bus.SrcB[WIDTH-1]) ? -bus.SrcB : bus.SrcB;

    mult_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .SHW            (SHW)
    ) u_step (
        .acc_in       (prod_q),
        .multiplicand (mcand_q),
        .mbits        (mplier_q[BITS_PER_CYCLE-1:0]),
        .shift        (shift),
        .acc_out      (prod_step)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = RUN;
            RUN:     if (bus.Flush) state_next = IDLE;
                     else if (last_step) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        prod_signed = (mode_q == SMULL_M && sign_q) ? -prod_q : prod_q;
        wide        = (mode_q == UMULL_M) || (mode_q == SMULL_M);
        fin_lo      = prod_signed[WIDTH-1:0];
        fin_hi      = '0;
        case (mode_q)
            MUL_M:   fin_lo = prod_q[WIDTH-1:0];
            MLA_M:   fin_lo = prod_q[WIDTH-1:0] + acc_q;
            default: fin_hi = prod_signed[2*WIDTH-1:WIDTH];
        endcase
        fin_flags         = '0;
        fin_flags[FLAG_N] = wide ? fin_hi[WIDTH-1] : fin_lo[WIDTH-1];
        fin_flags[FLAG_Z] = ({fin_hi, fin_lo} == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q   <= MUL_M;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            sign_q   <= 1'b0;
            count_q  <= '0;
            prod_q   <= '0;
            done_q   <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            flags_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (start_ok) begin
                    mode_q   <= mode_e'(bus.Mode);
                    acc_q    <= bus.AccIn;
                    mcand_q  <= a_mag;
                    mplier_q <= b_mag;
                    sign_q   <= is_smull && (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
                    count_q  <= '0;
                    prod_q   <= '0;
                end
                RUN: if (!bus.Flush) begin
                    prod_q   <= prod_step;
                    mplier_q <= mplier_q >> BITS_PER_CYCLE;
                    count_q  <= count_q + 1'b1;
                end
                FIN: if (!bus.Flush) begin
                    res_lo_q <= fin_lo;
                    res_hi_q <= fin_hi;
                    flags_q  <= fin_flags;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy     = (state != IDLE);
    assign bus.Done     = done_q;
    assign bus.ResultLo = res_lo_q;
    assign bus.ResultHi = res_hi_q;
    assign bus.FlagsOut = flags_q;

endmodule
